// File: rtl/acl_spi_responder_pkg.sv
// Shared register map, command codes and FSM encoding for the ADXL362 emulation.
// Used by the SPI responder and by the accelerometer master controller.
package acl_spi_responder_pkg;

   localparam logic [7:0] CMD_WR         = 8'h0A;
   localparam logic [7:0] CMD_RD         = 8'h0B;

   localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
   localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
   localparam logic [5:0] ADDR_PARTID    = 6'h02;
   localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
   localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
   localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
   localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
   localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
   localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
   localparam logic [5:0] ADDR_SOFT_RST  = 6'h1F;
   localparam logic [5:0] ADDR_FILTER    = 6'h2C;
   localparam logic [5:0] ADDR_POWER     = 6'h2D;

   localparam logic [7:0] FILTER_CTL_RST = 8'h13;
   localparam logic [7:0] POWER_CTL_RST  = 8'h00;
   localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_RD, ST_WR, ST_IGNORE
   } state_t;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [11:0] z;
   } snap_t;

   function automatic logic [7:0] sample_lo(input logic [11:0] s);
      return s[7:0];
   endfunction

   function automatic logic [7:0] sample_hi(input logic [11:0] s);
      return {{4{s[11]}}, s[11:8]};
   endfunction

endpackage

// File: rtl/acl_spi_responder_spi_pin_sync.sv
// Synchronizes SCLK/MOSI/CSN into CLK and produces one-cycle edge strobes.
// Latency: SYNC_STAGES+1 CLK from pin to strobe; no backpressure.
module acl_spi_responder_spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic sclk,
   input  logic mosi,
   input  logic csn,
   output logic mosi_s,
   output logic csn_s,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic csn_fall,
   output logic csn_rise
);

   logic [SYNC_STAGES-1:0] sclk_ff, mosi_ff, csn_ff;
   logic                   sclk_q, csn_q;
   logic                   sclk_s;

   // CSN flops reset high so leaving reset never fakes a select.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         sclk_ff <= '0;
         mosi_ff <= '0;
         csn_ff  <= '1;
         sclk_q  <= 1'b0;
         csn_q   <= 1'b1;
      end else begin
         sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
         csn_ff  <= {csn_ff[SYNC_STAGES-2:0], csn};
         sclk_q  <= sclk_s;
         csn_q   <= csn_s;
      end
   end

   assign sclk_s    = sclk_ff[SYNC_STAGES-1];
   assign mosi_s    = mosi_ff[SYNC_STAGES-1];
   assign csn_s     = csn_ff[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s &  sclk_q;
   assign csn_fall  = ~csn_s  &  csn_q;
   assign csn_rise  =  csn_s  & ~csn_q;

endmodule

// File: rtl/acl_spi_responder.sv
// ADXL362-style SPI mode-0 responder serving ID, snapshot XYZ data and two control registers.
// Latency: MISO updates SYNC_STAGES+1 CLK after SCLK fall; no backpressure (master paces everything).
module acl_spi_responder
   import acl_spi_responder_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID_AD    = 8'hAD,
   parameter logic [7:0] DEVID_MST   = 8'h1D,
   parameter logic [7:0] PARTID      = 8'hF2
) (
   input  logic        CLK,
   input  logic        rst_n,
   input  logic        ACL_SCLK,
   input  logic        ACL_MOSI,
   input  logic        ACL_CSN,
   output logic        ACL_MISO,
   input  logic [11:0] i_accel_x,
   input  logic [11:0] i_accel_y,
   input  logic [11:0] i_accel_z,
   output logic [7:0]  o_power_ctl,
   output logic [7:0]  o_filter_ctl,
   output logic        o_measuring,
   output logic        o_busy,
   output logic        o_bad_cmd
);

   logic       mosi_s, csn_s, sclk_rise, sclk_fall, csn_fall, csn_rise;
   state_t     state, state_nxt;
   logic [2:0] bit_cnt;
   logic [6:0] rx_sr;
   logic [7:0] tx_sr, rx_byte, rd_byte, power_ctl, filter_ctl;
   logic [5:0] ptr;
   logic       is_rd, load_pend, miso_q, byte_done, cmd_ok;
   snap_t      snap;

   acl_spi_responder_spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .sclk      (ACL_SCLK),
      .mosi      (ACL_MOSI),
      .csn       (ACL_CSN),
      .mosi_s    (mosi_s),
      .csn_s     (csn_s),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .csn_fall  (csn_fall),
      .csn_rise  (csn_rise)
   );

   // A CSN rise in the same cycle kills the byte, so partial or racing bytes never act.
   assign rx_byte   = {rx_sr, mosi_s};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !csn_rise && (state != ST_IDLE);
   assign cmd_ok    = (rx_byte == CMD_RD) || (rx_byte == CMD_WR);

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (csn_rise) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (csn_fall)  state_nxt = ST_CMD;
            ST_CMD:  if (byte_done) state_nxt = cmd_ok ? ST_ADDR : ST_IGNORE;
            ST_ADDR: if (byte_done) state_nxt = is_rd ? ST_RD : ST_WR;
            default: ;
         endcase
      end
   end

   always_comb begin
      ACL_MISO  = 1'b0;
      o_bad_cmd = 1'b0;
      if (state == ST_RD && !csn_s) ACL_MISO = miso_q;
      if (state == ST_CMD && byte_done && !cmd_ok) o_bad_cmd = 1'b1;
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         ptr       <= '0;
         is_rd     <= 1'b0;
         load_pend <= 1'b0;
         miso_q    <= 1'b0;
         snap      <= '0;
      end else if (csn_rise) begin
         bit_cnt   <= '0;
         load_pend <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         if (state == ST_IDLE && csn_fall) begin
            bit_cnt   <= '0;
            load_pend <= 1'b0;
            miso_q    <= 1'b0;
            snap      <= '{x: i_accel_x, y: i_accel_y, z: i_accel_z};
         end
         if (sclk_rise && state != ST_IDLE) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= {rx_sr[5:0], mosi_s};
         end
         if (byte_done) begin
            case (state)
               ST_CMD:  is_rd <= (rx_byte == CMD_RD);
               ST_ADDR: begin ptr <= rx_byte[5:0]; load_pend <= is_rd; end
               ST_RD:   begin ptr <= ptr + 6'd1;   load_pend <= 1'b1;  end
               ST_WR:   ptr <= ptr + 6'd1;
               default: ;
            endcase
         end
         // The first fall of each byte loads fresh data; later falls shift.
         if (sclk_fall && state == ST_RD) begin
            if (load_pend) begin
               miso_q    <= rd_byte[7];
               tx_sr     <= {rd_byte[6:0], 1'b0};
               load_pend <= 1'b0;
            end else begin
               miso_q <= tx_sr[7];
               tx_sr  <= {tx_sr[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         power_ctl  <= POWER_CTL_RST;
         filter_ctl <= FILTER_CTL_RST;
      end else if (byte_done && state == ST_WR) begin
         case (ptr)
            ADDR_FILTER: filter_ctl <= rx_byte;
            ADDR_POWER:  power_ctl  <= rx_byte;
            ADDR_SOFT_RST: begin
               if (rx_byte == SOFT_RESET_KEY) begin
                  power_ctl  <= POWER_CTL_RST;
                  filter_ctl <= FILTER_CTL_RST;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_power_ctl  = power_ctl;
   assign o_filter_ctl = filter_ctl;
   assign o_measuring  = (power_ctl[1:0] == 2'b10);
   assign o_busy       = ~csn_s;

   always_comb begin
      rd_byte = 8'h00;
      case (ptr)
         ADDR_DEVID_AD:  rd_byte = DEVID_AD;
         ADDR_DEVID_MST: rd_byte = DEVID_MST;
         ADDR_PARTID:    rd_byte = PARTID;
         ADDR_XDATA_L:   if (o_measuring) rd_byte = sample_lo(snap.x);
         ADDR_XDATA_H:   if (o_measuring) rd_byte = sample_hi(snap.x);
         ADDR_YDATA_L:   if (o_measuring) rd_byte = sample_lo(snap.y);
         ADDR_YDATA_H:   if (o_measuring) rd_byte = sample_hi(snap.y);
         ADDR_ZDATA_L:   if (o_measuring) rd_byte = sample_lo(snap.z);
         ADDR_ZDATA_H:   if (o_measuring) rd_byte = sample_hi(snap.z);
         ADDR_FILTER:    rd_byte = filter_ctl;
         ADDR_POWER:     rd_byte = power_ctl;
         default:        rd_byte = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Bench for acl_spi_responder: an SPI master task queues the expected MISO byte per byte sent,
// a monitor pops and compares each received byte; register outputs are checked directly.
module tb_acl_spi_responder;

   localparam int HALF = 8;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        ACL_SCLK = 1'b0;
   logic        ACL_MOSI = 1'b0;
   logic        ACL_CSN = 1'b1;
   logic        ACL_MISO;
   logic [11:0] i_accel_x = '0;
   logic [11:0] i_accel_y = '0;
   logic [11:0] i_accel_z = '0;
   logic [7:0]  o_power_ctl, o_filter_ctl;
   logic        o_measuring, o_busy, o_bad_cmd;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_b;
   logic        rx_vld = 1'b0;
   logic [7:0]  rx_dat = '0;
   logic        busy_drop = 1'b0;
   int          bad_hi = 0;

   acl_spi_responder dut (
      .CLK          (CLK),
      .rst_n        (rst_n),
      .ACL_SCLK     (ACL_SCLK),
      .ACL_MOSI     (ACL_MOSI),
      .ACL_CSN      (ACL_CSN),
      .ACL_MISO     (ACL_MISO),
      .i_accel_x    (i_accel_x),
      .i_accel_y    (i_accel_y),
      .i_accel_z    (i_accel_z),
      .o_power_ctl  (o_power_ctl),
      .o_filter_ctl (o_filter_ctl),
      .o_measuring  (o_measuring),
      .o_busy       (o_busy),
      .o_bad_cmd    (o_bad_cmd)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (o_bad_cmd === 1'b1) bad_hi++;

   // Scoreboard monitor: one queued expectation per byte clocked out of MISO.
   always @(posedge rx_vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL miso_byte: got %h, expected nothing queued", rx_dat);
      end else begin
         exp_b = exp_q.pop_front();
         if (rx_dat !== exp_b) begin
            n_fail++;
            $display("FAIL miso_byte: got %h, expected %h", rx_dat, exp_b);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp);
      logic [7:0] r;
      r = '0;
      exp_q.push_back(exp);
      for (int i = 7; i >= 0; i--) begin
         ACL_MOSI = tx[i];
         wait_clk(HALF);
         r[i] = ACL_MISO;
         if (o_busy !== 1'b1) busy_drop = 1'b1;
         ACL_SCLK = 1'b1;
         wait_clk(HALF);
         ACL_SCLK = 1'b0;
      end
      rx_dat = r;
      rx_vld = 1'b1;
      #1 rx_vld = 1'b0;
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         ACL_MOSI = tx[i];
         wait_clk(HALF);
         ACL_SCLK = 1'b1;
         wait_clk(HALF);
         ACL_SCLK = 1'b0;
      end
   endtask

   task automatic cs_lo();
      busy_drop = 1'b0;
      ACL_CSN = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_hi();
      wait_clk(HALF);
      ACL_CSN = 1'b1;
      wait_clk(HALF + 4);
   endtask

   initial begin
      wait_clk(4);
      check("rst_miso", ACL_MISO, 0);
      check("rst_power", o_power_ctl, 8'h00);
      check("rst_filter", o_filter_ctl, 8'h13);
      check("rst_busy", o_busy, 0);
      check("rst_bad_cmd", o_bad_cmd, 0);
      check("rst_measuring", o_measuring, 0);
      rst_n = 1'b1;
      wait_clk(4);

      // ID read
      cs_lo();
      spi_byte(8'h0B, 8'h00); spi_byte(8'h00, 8'h00);
      spi_byte(8'hFF, 8'hAD); spi_byte(8'hFF, 8'h1D); spi_byte(8'hFF, 8'hF2);
      check("id_busy_drop", busy_drop, 0);
      cs_hi();
      check("busy_idle", o_busy, 0);

      // write POWER_CTL then read it back
      cs_lo();
      spi_byte(8'h0A, 8'h00); spi_byte(8'h2D, 8'h00); spi_byte(8'h02, 8'h00);
      cs_hi();
      check("wr_power", o_power_ctl, 8'h02);
      check("wr_measuring", o_measuring, 1);
      cs_lo();
      spi_byte(8'h0B, 8'h00); spi_byte(8'h2D, 8'h00); spi_byte(8'hFF, 8'h02);
      cs_hi();

      // burst coherence: inputs change after the snapshot is taken
      i_accel_x = 12'hF85; i_accel_y = 12'h07F; i_accel_z = 12'h800;
      cs_lo();
      spi_byte(8'h0B, 8'h00);
      i_accel_x = 12'h123; i_accel_y = 12'h456; i_accel_z = 12'h7FF;
      spi_byte(8'h0E, 8'h00);
      spi_byte(8'hFF, 8'h85); spi_byte(8'hFF, 8'hFF);
      i_accel_x = 12'h000;
      spi_byte(8'hFF, 8'h7F); spi_byte(8'hFF, 8'h00);
      spi_byte(8'hFF, 8'h00); spi_byte(8'hFF, 8'hF8);
      cs_hi();

      // gating when not measuring
      i_accel_x = 12'hF85;
      cs_lo();
      spi_byte(8'h0A, 8'h00); spi_byte(8'h2D, 8'h00); spi_byte(8'h00, 8'h00);
      cs_hi();
      check("gate_measuring", o_measuring, 0);
      cs_lo();
      spi_byte(8'h0B, 8'h00); spi_byte(8'h0E, 8'h00);
      spi_byte(8'hFF, 8'h00); spi_byte(8'hFF, 8'h00);
      cs_hi();

      // unsupported command
      bad_hi = 0;
      cs_lo();
      spi_byte(8'h0D, 8'h00); spi_byte(8'h0B, 8'h00); spi_byte(8'hFF, 8'h00);
      cs_hi();
      check("bad_cmd_pulse", bad_hi, 1);

      // aborted write leaves FILTER_CTL alone
      cs_lo();
      spi_byte(8'h0A, 8'h00); spi_byte(8'h2C, 8'h00);
      spi_bits(8'hFF, 5);
      cs_hi();
      check("abort_filter", o_filter_ctl, 8'h13);

      // pointer wrap
      cs_lo();
      spi_byte(8'h0B, 8'h00); spi_byte(8'h3F, 8'h00);
      spi_byte(8'hFF, 8'h00); spi_byte(8'hFF, 8'hAD);
      cs_hi();

      // burst write, wrong soft-reset key, then correct key
      cs_lo();
      spi_byte(8'h0A, 8'h00); spi_byte(8'h2C, 8'h00);
      spi_byte(8'h55, 8'h00); spi_byte(8'h02, 8'h00);
      cs_hi();
      check("burst_wr_filter", o_filter_ctl, 8'h55);
      check("burst_wr_power", o_power_ctl, 8'h02);
      cs_lo();
      spi_byte(8'h0A, 8'h00); spi_byte(8'h1F, 8'h00); spi_byte(8'h51, 8'h00);
      cs_hi();
      check("badkey_filter", o_filter_ctl, 8'h55);
      cs_lo();
      spi_byte(8'h0A, 8'h00); spi_byte(8'h1F, 8'h00); spi_byte(8'h52, 8'h00);
      cs_hi();
      check("softrst_filter", o_filter_ctl, 8'h13);
      check("softrst_power", o_power_ctl, 8'h00);

      // rst_n mid-read
      cs_lo();
      spi_byte(8'h0A, 8'h00); spi_byte(8'h2D, 8'h00); spi_byte(8'h02, 8'h00);
      cs_hi();
      cs_lo();
      spi_byte(8'h0B, 8'h00); spi_byte(8'h00, 8'h00);
      wait_clk(4);
      check("pre_rst_miso", ACL_MISO, 1);
      rst_n = 1'b0;
      wait_clk(1);
      check("midrst_miso", ACL_MISO, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_power", o_power_ctl, 8'h00);
      check("midrst_filter", o_filter_ctl, 8'h13);
      ACL_CSN = 1'b1;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(HALF);
      cs_lo();
      spi_byte(8'h0B, 8'h00); spi_byte(8'h00, 8'h00); spi_byte(8'hFF, 8'hAD);
      cs_hi();

      wait_clk(4);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
